// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
//   Data-memory bus between the MEM stage (master) and the data memory or its
//   arbiter (slave).
//
//   master -> slave : dmem_req    request valid, held until dmem_gnt
//                     dmem_we     1 = store, 0 = load
//                     dmem_addr   doubleword-aligned byte address
//                     dmem_wdata  store data, already shifted into its lanes
//                     dmem_wstrb  per-byte write enables
//   slave -> master : dmem_gnt    request accepted this cycle
//                     dmem_rvalid read data valid / store acknowledged
//                     dmem_rdata  full doubleword containing the load
// -----------------------------------------------------------------------------
interface memory_access_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//   MEM pipeline stage of a 64-bit RISC-V core. Non-memory instructions pass
//   through to the MEM/WB register in one cycle. Loads and stores are issued on
//   the dmem bus through a three-state FSM (IDLE -> REQ -> WAIT) that stalls the
//   pipeline until the response arrives or the access times out.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in REQ+WAIT before the access is aborted
//                   with a bus_error pulse; 0 disables the timeout.
//
// Configuration macro
//   MISALIGN_TRAP_EN  when defined, misaligned H/W/D accesses are not issued;
//                     they pulse 'misaligned' and pass in one cycle. When not
//                     defined, 'misaligned' is tied low and such accesses go
//                     out with strobes truncated to the doubleword.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   alu_result_in                EX/MEM ALU result (written back for non-mem ops)
//   mem_address_in               EX/MEM effective address
//   mem_write_data_in            EX/MEM store data (rs2)
//   reg_write_in .. mem_to_reg_in EX/MEM control bits
//   rd_addr_in, funct3_in        destination register, access size/sign
//   dmem                         data-memory bus (master modport)
//   mem_stall                    combinational stall of EX/MEM and earlier
//   wb_reg_write, wb_rd_addr, wb_data  registered MEM/WB outputs
//   bus_error, misaligned        registered one-cycle pulses
// -----------------------------------------------------------------------------
module memory_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [63:0]           alu_result_in,
   input  logic [63:0]           mem_address_in,
   input  logic [63:0]           mem_write_data_in,
   input  logic                  reg_write_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  mem_to_reg_in,
   input  logic [4:0]            rd_addr_in,
   input  logic [2:0]            funct3_in,
   memory_access_if.master       dmem,
   output logic                  mem_stall,
   output logic                  wb_reg_write,
   output logic [4:0]            wb_rd_addr,
   output logic [63:0]           wb_data,
   output logic                  bus_error,
   output logic                  misaligned
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;

   // Operation captured when the access leaves IDLE; drives the bus while stalled.
   logic [63:0]       op_addr;
   logic [63:0]       op_wdata;
   logic [2:0]        op_funct3;
   logic [4:0]        op_rd;
   logic              op_we;
   logic              op_reg_write;
   logic              latch_en;

   logic              mem_op;
   logic              trap;
   logic              timeout_hit;
   logic              stall_raw;

   logic              wb_we_d;
   logic [4:0]        wb_rd_d;
   logic [63:0]       wb_data_d;
   logic              bus_error_d;
   logic              misaligned_d;

   logic [7:0]        strb_base;
   logic [63:0]       lane;
   logic [63:0]       load_data;

   // mem_to_reg is implied by mem_read in this stage; kept for port compatibility.
   logic              unused_mem_to_reg;
   assign unused_mem_to_reg = mem_to_reg_in;

   assign mem_op      = mem_read_in | mem_write_in;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   // --------------------------------------------------------------------------
   // Misalignment trap
   // --------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
   logic mis_access;

   always_comb begin
      mis_access = 1'b0;
      unique case (funct3_in[1:0])
         2'b00:   mis_access = 1'b0;
         2'b01:   mis_access = mem_address_in[0];
         2'b10:   mis_access = |mem_address_in[1:0];
         default: mis_access = |mem_address_in[2:0];
      endcase
   end

   assign trap = mem_op & mis_access;
`else
   assign trap = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Bus outputs, driven from the captured operation
   // --------------------------------------------------------------------------
   always_comb begin
      strb_base = 8'h00;
      unique case (op_funct3[1:0])
         2'b00:   strb_base = 8'h01;
         2'b01:   strb_base = 8'h03;
         2'b10:   strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
   end

   // Strobes shifted past byte 7 are dropped rather than wrapped.
   assign dmem.dmem_req   = (state == REQ) && !rst;
   assign dmem.dmem_we    = op_we;
   assign dmem.dmem_addr  = {op_addr[63:3], 3'b000};
   assign dmem.dmem_wdata = op_wdata << {op_addr[2:0], 3'b000};
   assign dmem.dmem_wstrb = strb_base << op_addr[2:0];

   // --------------------------------------------------------------------------
   // Load lane extraction and extension
   // --------------------------------------------------------------------------
   assign lane = dmem.dmem_rdata >> {op_addr[2:0], 3'b000};

   always_comb begin
      load_data = lane;
      unique case (op_funct3)
         3'b000:  load_data = {{56{lane[7]}},  lane[7:0]};
         3'b001:  load_data = {{48{lane[15]}}, lane[15:0]};
         3'b010:  load_data = {{32{lane[31]}}, lane[31:0]};
         3'b100:  load_data = {56'd0, lane[7:0]};
         3'b101:  load_data = {48'd0, lane[15:0]};
         3'b110:  load_data = {32'd0, lane[31:0]};
         default: load_data = lane;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM next state and MEM/WB next values
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      latch_en     = 1'b0;
      stall_raw    = 1'b0;
      wb_we_d      = 1'b0;
      wb_rd_d      = wb_rd_addr;
      wb_data_d    = wb_data;
      bus_error_d  = 1'b0;
      misaligned_d = 1'b0;

      unique case (state)
         IDLE: begin
            if (trap) begin
               misaligned_d = 1'b1;
               wb_rd_d      = rd_addr_in;
            end else if (mem_op) begin
               latch_en  = 1'b1;
               stall_raw = 1'b1;
               cnt_d     = '0;
               state_d   = REQ;
            end else begin
               wb_we_d   = reg_write_in && (rd_addr_in != 5'd0);
               wb_rd_d   = rd_addr_in;
               wb_data_d = alu_result_in;
            end
         end

         REQ, WAIT: begin
            // Completion beats timeout; timeout beats a bare grant. A response
            // in REQ only counts when it comes with the grant.
            if ((state == WAIT && dmem.dmem_rvalid) ||
                (state == REQ && dmem.dmem_gnt && dmem.dmem_rvalid)) begin
               state_d = IDLE;
               wb_we_d = !op_we && op_reg_write && (op_rd != 5'd0);
               wb_rd_d = op_rd;
               if (!op_we) begin
                  wb_data_d = load_data;
               end
            end else if (timeout_hit) begin
               state_d     = IDLE;
               bus_error_d = 1'b1;
            end else begin
               stall_raw = 1'b1;
               if (state == REQ && dmem.dmem_gnt) begin
                  state_d = WAIT;
               end
               if (TIMEOUT_CYCLES != 0) begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_stall = stall_raw && !rst;

   // --------------------------------------------------------------------------
   // State, captured operation and MEM/WB registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         op_addr      <= '0;
         op_wdata     <= '0;
         op_funct3    <= '0;
         op_rd        <= '0;
         op_we        <= 1'b0;
         op_reg_write <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd_addr   <= '0;
         wb_data      <= '0;
         bus_error    <= 1'b0;
         misaligned   <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         if (latch_en) begin
            op_addr      <= mem_address_in;
            op_wdata     <= mem_write_data_in;
            op_funct3    <= funct3_in;
            op_rd        <= rd_addr_in;
            op_we        <= mem_write_in;
            op_reg_write <= reg_write_in;
         end
         wb_reg_write <= wb_we_d;
         wb_rd_addr   <= wb_rd_d;
         wb_data      <= wb_data_d;
         bus_error    <= bus_error_d;
         misaligned   <= misaligned_d;
      end
   end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max REQ+WAIT cycles before abort; 0 disables timeout.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 alu_result_in, mem_address_in, mem_write_data_in  in  64 each  EX/MEM payload.
REQ-005 reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  EX/MEM controls.
REQ-006 rd_addr_in  in  5 and funct3_in  in  3; destination register and access size/sign.
REQ-007 dmem_req  out  1  request valid; dmem_we  out  1  write enable.
REQ-008 dmem_addr  out  64  address, aligned down to 8 bytes; dmem_wdata  out  64  lane-shifted write data; dmem_wstrb  out  8  byte enables.
REQ-009 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  response/ack; dmem_rdata  in  64  read doubleword.
REQ-010 mem_stall  out  1  combinational; holds EX/MEM and all earlier stages.
REQ-011 wb_reg_write  out  1, wb_rd_addr  out  5, wb_data  out  64  registered MEM/WB outputs.
REQ-012 bus_error  out  1 and misaligned  out  1; registered one-cycle pulses.

Function
REQ-013 FSM states IDLE, REQ, WAIT; memory op = mem_read_in|mem_write_in.
REQ-014 IDLE, no memory op: next edge wb_data<=alu_result_in, wb_rd_addr<=rd_addr_in, wb_reg_write<=reg_write_in; latency 1; mem_stall=0.
REQ-015 IDLE, memory op: latch addr/wdata/funct3/rd/we; go to REQ; mem_stall=1; wb_reg_write<=0.
REQ-016 REQ: dmem_req=1, outputs stable until dmem_gnt; dmem_gnt=1 goes to WAIT; dmem_gnt&dmem_rvalid in the same cycle completes directly.
REQ-017 WAIT: dmem_req=0; dmem_rvalid=1 completes: mem_stall=0 that cycle, state to IDLE, MEM/WB loaded at that edge.
REQ-018 mem_stall=1 in REQ/WAIT except the completion or timeout cycle; wb_reg_write=0 on every stalled cycle.
REQ-019 Load completion: wb_data = lane at addr[2:0]. LB/LH/LW sign-extend (funct3 000/001/010). LD full (011). LBU/LHU/LWU zero-extend (100/101/110).
REQ-020 Store: dmem_wdata = rs2 data << 8*addr[2:0]. dmem_wstrb = SB 0x01, SH 0x03, SW 0x0F, SD 0xFF, shifted << addr[2:0], truncated to 8 bits. Completion wb_reg_write=0.
REQ-021 wb_reg_write forced 0 when rd is x0.
REQ-022 Timeout counter: cleared entering REQ, increments in REQ/WAIT. At TIMEOUT_CYCLES without completion: return to IDLE, bus_error pulse, wb_reg_write=0, mem_stall=0.
REQ-023 dmem_rvalid in IDLE, or in REQ without dmem_gnt, is ignored.

Reset
REQ-024 rst at any state: next edge state=IDLE, counter=0, all outputs 0 (dmem_req, mem_stall, wb_*, bus_error, misaligned).
REQ-025 A response arriving after reset mid-operation is ignored.

Configuration
REQ-026 Macro MISALIGN_TRAP_EN. When defined, a misaligned access issues no request, pulses misaligned, sets wb_reg_write=0, and passes in 1 cycle with no stall. Misaligned means H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0.
REQ-027 Without MISALIGN_TRAP_EN: misaligned tied 0; access issued per REQ-020 with truncated strobes.

Verification
REQ-028 ADD rd=5, alu_result=0x2A -> next cycle wb_reg_write=1, wb_rd_addr=5, wb_data=0x2A, no stall.
REQ-029 LB addr 0x1003, rdata 0x00000000_80000000, gnt 1 cycle later, rvalid 2 later -> dmem_addr 0x1000, wb_data 0xFFFF_FFFF_FFFF_FF80, mem_stall high 3 cycles.
REQ-030 SH addr 0x2006, data 0xBEEF, zero-wait gnt+rvalid -> dmem_wstrb 0xC0, dmem_wdata 0xBEEF<<48, wb_reg_write=0.
REQ-031 LD, no rvalid, TIMEOUT_CYCLES=4 -> bus_error pulse after 4 cycles, stall released, FSM IDLE.
REQ-032 rst asserted in WAIT, then late rvalid -> IDLE, dmem_req=0, no wb write. With MISALIGN_TRAP_EN, LW 0x3002 -> misaligned=1, dmem_req never asserted.
